// File: rtl/day_select.sv
// rtl/day_select.sv - day-of-week register with debounced SET/UP/DOWN editing and blink control

// Button conditioner: 2-flop synchronizer, stability counter, rising-edge press pulse
module day_select_debounce #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn,
   output logic o_press
);

   logic        r_sync1;
   logic        r_sync2;
   logic        r_level;
   logic        r_level_d;
   logic [15:0] r_cnt;

   // Two-stage synchronizer for the asynchronous raw button
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
      end
   end

   // Debounced level follows the synchronized level only after it has held for DEBOUNCE_CYCLES samples
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_level <= 1'b0;
         r_cnt   <= 16'd0;
      end else if (r_sync2 != r_level) begin
         if (r_cnt == DEBOUNCE_CYCLES - 16'd1) begin
            r_level <= r_sync2;
            r_cnt   <= 16'd0;
         end else begin
            r_cnt <= r_cnt + 16'd1;
         end
      end else begin
         r_cnt <= 16'd0;
      end
   end

   // Delayed debounced level for edge detection
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_level_d <= 1'b0;
      end else begin
         r_level_d <= r_level;
      end
   end

   // Only presses produce a pulse; releases are silent and holding gives a single pulse
   assign o_press = r_level & ~r_level_d;

endmodule

// Top: RUN/SET mode machine holding the 0..6 day code consumed by the segment decoder
module day_select #(
   parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000,
   parameter logic [23:0] BLINK_HALF      = 24'd5000000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_set,
   input  logic       btn_up,
   input  logic       btn_down,
   input  logic       day_tick,
   output logic [2:0] seg,
   output logic       setting,
   output logic       blank,
   output logic       day_changed
);

   typedef enum logic {S_RUN, S_SET} state_t;

   state_t      r_state;
   logic [2:0]  r_seg;
   logic        r_setting;
   logic        r_blank;
   logic        r_day_changed;
   logic [23:0] r_blink_cnt;

   logic        w_set_p;
   logic        w_up_p;
   logic        w_down_p;
   logic        w_edit;
   logic [2:0]  w_inc;
   logic [2:0]  w_dec;
   logic [2:0]  w_edit_val;

   day_select_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_set (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_btn   (btn_set),
      .o_press (w_set_p)
   );

   day_select_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_btn   (btn_up),
      .o_press (w_up_p)
   );

   day_select_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_down (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_btn   (btn_down),
      .o_press (w_down_p)
   );

   // Modulo-7 neighbours of the current code; the illegal code 7 always recovers to Mon
   always_comb begin
      w_inc = (r_seg >= 3'd6) ? 3'd0 : r_seg + 3'd1;
      case (r_seg)
         3'd0:    w_dec = 3'd6;
         3'd7:    w_dec = 3'd0;
         default: w_dec = r_seg - 3'd1;
      endcase
   end

   // Simultaneous up and down cancel each other out
   assign w_edit     = w_up_p ^ w_down_p;
   assign w_edit_val = w_up_p ? w_inc : w_dec;

   // Mode machine: set press dominates, edits only in SET, midnight tick only in RUN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= S_RUN;
         r_seg         <= 3'd0;
         r_setting     <= 1'b0;
         r_blank       <= 1'b0;
         r_day_changed <= 1'b0;
         r_blink_cnt   <= 24'd0;
      end else begin
         r_day_changed <= 1'b0;
         case (r_state)
            S_RUN: begin
               if (day_tick) begin
                  r_seg         <= w_inc;
                  r_day_changed <= 1'b1;
               end
               if (w_set_p) begin
                  r_state     <= S_SET;
                  r_setting   <= 1'b1;
                  r_blank     <= 1'b0;
                  r_blink_cnt <= 24'd0;
               end
            end
            S_SET: begin
               if (w_set_p) begin
                  r_state     <= S_RUN;
                  r_setting   <= 1'b0;
                  r_blank     <= 1'b0;
                  r_blink_cnt <= 24'd0;
               end else if (w_edit) begin
                  // Show the freshly edited value straight away and restart the blink phase
                  r_seg         <= w_edit_val;
                  r_day_changed <= 1'b1;
                  r_blank       <= 1'b0;
                  r_blink_cnt   <= 24'd0;
               end else if (r_blink_cnt == BLINK_HALF - 24'd1) begin
                  r_blank     <= ~r_blank;
                  r_blink_cnt <= 24'd0;
               end else begin
                  r_blink_cnt <= r_blink_cnt + 24'd1;
               end
            end
            default: begin
               r_state <= S_RUN;
            end
         endcase
      end
   end

   assign seg         = r_seg;
   assign setting     = r_setting;
   assign blank       = r_blank;
   assign day_changed = r_day_changed;

endmodule

// File: tb/tb_day_select.sv
// tb/tb_day_select.sv - directed self-checking bench for day_select

module tb_day_select;

   logic       clk;
   logic       rst_n;
   logic       btn_set;
   logic       btn_up;
   logic       btn_down;
   logic       day_tick;
   logic [2:0] seg;
   logic       setting;
   logic       blank;
   logic       day_changed;

   int n_cmp = 0;
   int n_mis = 0;
   int dc_cnt = 0;
   int dc_ref;
   logic [2:0] prev_seg;

   day_select #(
      .DEBOUNCE_CYCLES (16'd4),
      .BLINK_HALF      (24'd8)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_set     (btn_set),
      .btn_up      (btn_up),
      .btn_down    (btn_down),
      .day_tick    (day_tick),
      .seg         (seg),
      .setting     (setting),
      .blank       (blank),
      .day_changed (day_changed)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Count every day_changed pulse seen mid-cycle
   always @(negedge clk) if (day_changed === 1'b1) dc_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // which: 0=set 1=up 2=down 3=up+down 4=set+up
   task automatic press(input int which, input int hold);
      case (which)
         0: btn_set = 1'b1;
         1: btn_up = 1'b1;
         2: btn_down = 1'b1;
         3: begin btn_up = 1'b1; btn_down = 1'b1; end
         default: begin btn_set = 1'b1; btn_up = 1'b1; end
      endcase
      repeat (hold) @(negedge clk);
      btn_set = 1'b0;
      btn_up = 1'b0;
      btn_down = 1'b0;
      repeat (10) @(negedge clk);
   endtask

   task automatic tick();
      day_tick = 1'b1;
      @(negedge clk);
      day_tick = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      btn_set = 1'b0;
      btn_up = 1'b0;
      btn_down = 1'b0;
      day_tick = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_seg", seg, 0);
      check("rst_setting", setting, 0);
      check("rst_blank", blank, 0);
      check("rst_day_changed", day_changed, 0);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      // RUN: seven midnight ticks walk Tue..Sun then wrap to Mon
      for (int i = 0; i < 7; i++) begin
         tick();
         check("run_tick_seg", seg, (i + 1) % 7);
         check("run_tick_dc", day_changed, 1);
         repeat (9) @(negedge clk);
         check("run_setting", setting, 0);
         check("run_blank", blank, 0);
      end
      check("run_dc_count", dc_cnt, 7);

      // Debounce: long set hold toggles once, short up glitch ignored, held down decrements
      press(0, 20);
      check("hold_set_one_toggle", setting, 1);
      dc_ref = dc_cnt;
      press(1, 3);
      check("glitch_up_seg", seg, 0);
      check("glitch_up_dc", dc_cnt, dc_ref);
      press(2, 6);
      check("down_wrap_seg", seg, 6);
      check("down_wrap_dc", dc_cnt, dc_ref + 1);

      // Back to RUN and tick up to Wed
      press(0, 6);
      check("exit_setting", setting, 0);
      check("exit_blank", blank, 0);
      tick(); tick(); tick();
      check("run_to_wed", seg, 2);

      // SET edits
      press(0, 6);
      check("enter_set", setting, 1);
      for (int i = 0; i < 5; i++) press(1, 6);
      check("up5_seg", seg, 0);
      press(2, 6);
      check("down1_seg", seg, 6);
      dc_ref = dc_cnt;
      tick();
      repeat (3) @(negedge clk);
      check("set_tick_ignored", seg, 6);
      check("set_tick_no_dc", dc_cnt, dc_ref);
      press(0, 6);
      check("exit2_setting", setting, 0);
      check("exit2_blank", blank, 0);

      // Blink timing from SET entry
      btn_set = 1'b1;
      begin : wait_entry
         for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (i == 5) btn_set = 1'b0;
            if (setting === 1'b1) disable wait_entry;
         end
      end
      btn_set = 1'b0;
      check("blink_entry_setting", setting, 1);
      check("blink_entry_blank", blank, 0);
      repeat (7) @(negedge clk);
      check("blink_on_end", blank, 0);
      @(negedge clk);
      check("blink_first_off", blank, 1);
      repeat (8) @(negedge clk);
      check("blink_second_on", blank, 0);
      repeat (8) @(negedge clk);
      check("blink_second_off", blank, 1);
      // Up press mid off-phase forces the display on and restarts the count
      prev_seg = seg;
      btn_up = 1'b1;
      begin : wait_edit
         for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (i == 5) btn_up = 1'b0;
            if (seg !== prev_seg) disable wait_edit;
         end
      end
      btn_up = 1'b0;
      check("blink_edit_seg", seg, 0);
      check("blink_edit_blank", blank, 0);
      check("blink_edit_dc", day_changed, 1);
      repeat (7) @(negedge clk);
      check("blink_restart_on", blank, 0);
      @(negedge clk);
      check("blink_restart_off", blank, 1);
      repeat (10) @(negedge clk);

      // Simultaneous up and down cancel
      dc_ref = dc_cnt;
      press(3, 6);
      check("updown_seg", seg, 0);
      check("updown_no_dc", dc_cnt, dc_ref);
      // Set coincident with up: mode changes, seg untouched
      press(4, 6);
      check("setup_setting", setting, 0);
      check("setup_seg", seg, 0);

      // Tick coincident with set press in RUN: both take effect
      btn_set = 1'b1;
      repeat (6) @(negedge clk);
      day_tick = 1'b1;
      @(negedge clk);
      day_tick = 1'b0;
      btn_set = 1'b0;
      check("tickset_seg", seg, 1);
      check("tickset_setting", setting, 1);
      check("tickset_dc", day_changed, 1);
      repeat (10) @(negedge clk);

      // Reset mid-SET with blank high and a debounce in progress
      for (int i = 0; i < 4; i++) press(1, 6);
      check("pre_reset_seg", seg, 5);
      begin : wait_blank
         for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (blank === 1'b1) disable wait_blank;
         end
      end
      check("pre_reset_blank", blank, 1);
      btn_down = 1'b1;
      repeat (3) @(negedge clk);
      rst_n = 1'b0;
      btn_down = 1'b0;
      #1;
      check("async_rst_seg", seg, 0);
      check("async_rst_setting", setting, 0);
      check("async_rst_blank", blank, 0);
      @(negedge clk);
      rst_n = 1'b1;
      dc_ref = dc_cnt;
      repeat (20) @(negedge clk);
      check("post_rst_seg", seg, 0);
      check("post_rst_setting", setting, 0);
      check("post_rst_no_dc", dc_cnt, dc_ref);
      tick();
      check("post_rst_run_tick", seg, 1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
